// File: rtl/register_file_sb_pkg.sv
// rtl/register_file_sb_pkg.sv - shared constants and helpers for the register file slice
package register_file_sb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    // Select width for a register file of nregs entries (nregs is a power of 2)
    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// rtl/register_file_sb_if.sv - decode/writeback bus into the register file
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
);
    localparam int AW = addr_width(NREGS);

    logic [NRD*AW-1:0]   rs_sel_in;
    logic [NRD*XLEN-1:0] rs_value_out;
    logic [NRD-1:0]      rs_busy_out;
    logic                write_enable_in;
    logic [AW-1:0]       rd_sel_in;
    logic [XLEN-1:0]     write_data_in;
    logic                alloc_valid_in;
    logic [AW-1:0]       alloc_sel_in;
    logic                flush_in;
    logic [AW:0]         busy_count_out;

    modport master (
        output rs_sel_in, write_enable_in, rd_sel_in, write_data_in,
               alloc_valid_in, alloc_sel_in, flush_in,
        input  rs_value_out, rs_busy_out, busy_count_out
    );

    modport slave (
        input  rs_sel_in, write_enable_in, rd_sel_in, write_data_in,
               alloc_valid_in, alloc_sel_in, flush_in,
        output rs_value_out, rs_busy_out, busy_count_out
    );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// rtl/register_file_sb_scoreboard.sv - per-register busy bits with alloc/write/flush priority
module rf_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = addr_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid_i,
    input  logic [AW-1:0]    alloc_sel_i,
    input  logic             write_enable_i,
    input  logic [AW-1:0]    rd_sel_i,
    input  logic             flush_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      busy_count_o
);
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      count_q, count_d;

    // Next busy vector: flush beats everything; alloc is applied after write so a
    // same-cycle alloc of the retiring register keeps it busy for the newer producer
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (write_enable_i && rd_sel_i != AW'(REG_ZERO)) begin
                busy_d[rd_sel_i] = 1'b0;
            end
            if (alloc_valid_i && alloc_sel_i != AW'(REG_ZERO)) begin
                busy_d[alloc_sel_i] = 1'b1;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Popcount of the current busy vector; registered, so the count trails busy by a cycle
    always_comb begin
        count_d = '0;
        for (int r = 1; r < NREGS; r++) begin
            count_d = count_d + {{AW{1'b0}}, busy_q[r]};
        end
    end

    // Busy vector and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - register file with async reads, write bypass and busy scoreboard
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    register_file_sb_if.slave bus
);
    localparam int AW = addr_width(NREGS);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [NREGS-1:0]    busy_w;
    logic [NRD*XLEN-1:0] rs_value_w;
    logic [NRD-1:0]      rs_busy_w;
    logic                wr_ok;

    // Writes to register 0 are dropped, so wr_ok also implies a non-zero destination
    assign wr_ok = bus.write_enable_in && (bus.rd_sel_in != AW'(REG_ZERO));

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid_i  (bus.alloc_valid_in),
        .alloc_sel_i    (bus.alloc_sel_in),
        .write_enable_i (bus.write_enable_in),
        .rd_sel_i       (bus.rd_sel_in),
        .flush_i        (bus.flush_in),
        .busy_o         (busy_w),
        .busy_count_o   (bus.busy_count_out)
    );

    // Register array; register 0 is cleared at reset and never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[bus.rd_sel_in] <= bus.write_data_in;
        end
    end

    // Read ports; forwarding is suppressed during reset so reads stay zero while rst is high
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] sel;
        logic          fwd;

        assign sel = bus.rs_sel_in[i*AW +: AW];
        assign fwd = (BYPASS != 0) && !rst && wr_ok && (bus.rd_sel_in == sel);

        assign rs_value_w[i*XLEN +: XLEN] = (sel == AW'(REG_ZERO)) ? '0 :
                                            fwd                    ? bus.write_data_in :
                                                                     regs_q[sel];
        assign rs_busy_w[i] = busy_w[sel] & ~fwd;
    end

    assign bus.rs_value_out = rs_value_w;
    assign bus.rs_busy_out  = rs_busy_w;

endmodule
